column_scheduler: RTL and testbench

Per-frame column sequencer for the raycaster back end. It walks camera column x from 0 to WIDTH-1 and runs three units in order for each column: the wall caster, the sprite culler (sprite_scanline) and the column line writer. Wall casting of column x+1 overlaps culling and drawing of column x. The sprite culler's cached sprite set is never overwritten before the line writer has consumed it.

---
 rtl/raycast_pkg.sv | 29 ++
 rtl/column_sched_stats.sv | 29 ++
 rtl/column_scheduler.sv | 140 ++++++++++++++
 tb/tb_column_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared types and widths for the raycaster back end: column widths,
// FSM state enums and a saturating-increment helper.
package raycast_pkg;

  localparam int SCREEN_WIDTH = 320;
  localparam int X_W          = 9;
  localparam int Z_W          = 16;
  localparam int STAT_W       = 24;

  typedef enum logic [1:0] {
    C_IDLE,
    C_START,
    C_WAIT,
    C_XFER
  } cast_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CULL_START,
    S_CULL_WAIT,
    S_DRAW_START,
    S_DRAW_WAIT
  } spr_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/column_sched_stats.sv
// Per-frame saturating cycle counters for column_scheduler; only
// instantiated when COLUMN_SCHED_STATS_EN is defined.
module column_sched_stats
  import raycast_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              busy,
  input  logic              stall,
  output logic [STAT_W-1:0] frame_cycles,
  output logic [STAT_W-1:0] stall_cycles
);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cycles <= '0;
      stall_cycles <= '0;
    end else if (clear) begin
      // The accepting cycle is already a busy cycle, so the count restarts at 1.
      frame_cycles <= STAT_W'(1);
      stall_cycles <= '0;
    end else begin
      if (busy)  frame_cycles <= sat_inc(frame_cycles);
      if (stall) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: rtl/column_scheduler.sv
// Per-frame column sequencer: wall cast of column x+1 overlaps cull/draw of x.
// Optional statistics counters are enabled by defining COLUMN_SCHED_STATS_EN.
module column_scheduler
  import raycast_pkg::*;
#(
  parameter int WIDTH = SCREEN_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_start,
  output logic           frame_done,
  output logic           busy,
  output logic           wall_start,
  output logic [X_W-1:0] cast_x,
  input  logic           wall_done,
  input  logic [Z_W-1:0] wall_z,
  output logic           cull_start,
  output logic [X_W-1:0] cull_x,
  output logic [Z_W-1:0] cull_wall_z,
  input  logic           cull_done,
  output logic           draw_start,
  output logic [X_W-1:0] draw_x,
  input  logic           draw_done
`ifdef COLUMN_SCHED_STATS_EN
  ,
  output logic [23:0]    frame_cycles,
  output logic [23:0]    stall_cycles
`endif
);

  localparam logic [X_W-1:0] LAST_X = X_W'(WIDTH - 1);

  cast_state_t    cast_q, cast_d;
  spr_state_t     spr_q, spr_d;
  logic           busy_q;
  logic           last_q;
  logic [Z_W-1:0] hold_z;

  logic accept;
  logic xfer_pulse;
  logic cast_last;

  assign accept     = frame_start && !busy_q;
  assign xfer_pulse = (cast_q == C_XFER) && (spr_q == S_IDLE);
  assign cast_last  = (cast_x == LAST_X);
  assign busy       = busy_q || frame_start;
  assign draw_x     = cull_x;

  // NOTE: every output of a combinational block gets a default before the
  // case statement; otherwise an unassigned path infers a latch.
  always_comb begin
    cast_d     = cast_q;
    wall_start = 1'b0;
    case (cast_q)
      C_IDLE:  if (accept) cast_d = C_START;
      C_START: begin
        wall_start = 1'b1;
        cast_d     = C_WAIT;
      end
      C_WAIT:  if (wall_done) cast_d = C_XFER;
      C_XFER:  if (xfer_pulse) cast_d = cast_last ? C_IDLE : C_START;
      default: cast_d = C_IDLE;
    endcase
  end

  // Only one column lives in the sprite path, which protects the culler's cache.
  always_comb begin
    spr_d      = spr_q;
    cull_start = 1'b0;
    draw_start = 1'b0;
    frame_done = 1'b0;
    case (spr_q)
      S_IDLE:       if (xfer_pulse) spr_d = S_CULL_START;
      S_CULL_START: begin
        cull_start = 1'b1;
        spr_d      = S_CULL_WAIT;
      end
      S_CULL_WAIT:  if (cull_done) spr_d = S_DRAW_START;
      S_DRAW_START: begin
        draw_start = 1'b1;
        spr_d      = S_DRAW_WAIT;
      end
      S_DRAW_WAIT:  if (draw_done) begin
        spr_d      = S_IDLE;
        frame_done = last_q;
      end
      default:      spr_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: all state here is plain flops (no memories), so everything is
    // cleared by the synchronous reset.
    if (rst) begin
      cast_q      <= C_IDLE;
      spr_q       <= S_IDLE;
      busy_q      <= 1'b0;
      last_q      <= 1'b0;
      cast_x      <= '0;
      hold_z      <= '0;
      cull_x      <= '0;
      cull_wall_z <= '0;
    end else begin
      cast_q <= cast_d;
      spr_q  <= spr_d;

      if (accept)          busy_q <= 1'b1;
      else if (frame_done) busy_q <= 1'b0;

      if (accept)                       cast_x <= '0;
      else if (xfer_pulse && !cast_last) cast_x <= cast_x + X_W'(1);

      if (cast_q == C_WAIT && wall_done) hold_z <= wall_z;

      if (xfer_pulse) begin
        cull_x      <= cast_x;
        cull_wall_z <= hold_z;
        last_q      <= cast_last;
      end
    end
  end

`ifdef COLUMN_SCHED_STATS_EN
  logic stall;
  assign stall = (cast_q == C_XFER) && (spr_q != S_IDLE);

  column_sched_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .busy         (busy_q),
    .stall        (stall),
    .frame_cycles (frame_cycles),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_column_scheduler.sv
// Self-checking bench for column_scheduler: two instances (WIDTH 4 and 320),
// randomized unit latencies, event-time reference model of the column schedule.
module tb_column_scheduler;
  import raycast_pkg::*;

  localparam int NI = 2;
  localparam int LANE_W [NI] = '{4, 320};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        frame_start [NI];
  logic        frame_done  [NI];
  logic        busy        [NI];
  logic        wall_start  [NI];
  logic [8:0]  cast_x      [NI];
  logic        wall_done   [NI];
  logic [15:0] wall_z      [NI];
  logic        cull_start  [NI];
  logic [8:0]  cull_x      [NI];
  logic [15:0] cull_wall_z [NI];
  logic        cull_done   [NI];
  logic        draw_start  [NI];
  logic [8:0]  draw_x      [NI];
  logic        draw_done   [NI];
`ifdef COLUMN_SCHED_STATS_EN
  logic [23:0] frame_cycles [NI];
  logic [23:0] stall_cycles [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_lane
    column_scheduler #(.WIDTH(LANE_W[g])) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start[g]),
      .frame_done  (frame_done[g]),
      .busy        (busy[g]),
      .wall_start  (wall_start[g]),
      .cast_x      (cast_x[g]),
      .wall_done   (wall_done[g]),
      .wall_z      (wall_z[g]),
      .cull_start  (cull_start[g]),
      .cull_x      (cull_x[g]),
      .cull_wall_z (cull_wall_z[g]),
      .cull_done   (cull_done[g]),
      .draw_start  (draw_start[g]),
      .draw_x      (draw_x[g]),
      .draw_done   (draw_done[g])
`ifdef COLUMN_SCHED_STATS_EN
      ,
      .frame_cycles (frame_cycles[g]),
      .stall_cycles (stall_cycles[g])
`endif
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Unit latency ranges and spurious-pulse requests, written by the stimulus.
  int wl_lo [NI], wl_hi [NI], cl_lo [NI], cl_hi [NI], dl_lo [NI], dl_hi [NI];
  int spur_req [NI];

  // Reference model: expected event times derived from the scheduling rules.
  bit          m_in_frame [NI];
  int          exp_ws [NI], exp_cs [NI], exp_ds [NI];
  int          ws_t [NI], cs_t [NI], ds_t [NI], wd_t [NI], free_at [NI];
  bit          wait_wd [NI], wait_cd [NI], wait_dd [NI];
  bit          have_hold [NI], spr_busy [NI], post_rst [NI];
  int          cast_col [NI], hold_x [NI], spr_x [NI];
  logic [15:0] hold_z [NI], spr_z [NI];
  int          m_draws [NI], m_fdones [NI], m_busy_cyc [NI], m_stall [NI];

  // Behavioural wall caster / culler / line writer state.
  int          wc [NI], cc [NI], dc [NI], wx [NI], spur_srv [NI];
  bit          nwd [NI], ncd [NI], ndd [NI];
  logic [15:0] nz [NI];

  task automatic reset_model(input int g);
    m_in_frame[g] = 0;
    exp_ws[g] = -1; exp_cs[g] = -1; exp_ds[g] = -1;
    wait_wd[g] = 0; wait_cd[g] = 0; wait_dd[g] = 0;
    have_hold[g] = 0; spr_busy[g] = 0;
    cast_col[g] = 0; free_at[g] = 0;
  endtask

  task automatic model_step(input int g);
    int  w      = LANE_W[g];
    bit  was_in = m_in_frame[g];
    bit  acc_dd = draw_done[g] && wait_dd[g] && (cyc > ds_t[g]);
    int  xf;
    check("busy",       busy[g],       was_in || frame_start[g]);
    check("wall_start", wall_start[g], cyc == exp_ws[g]);
    check("cull_start", cull_start[g], cyc == exp_cs[g]);
    check("draw_start", draw_start[g], cyc == exp_ds[g]);
    check("frame_done", frame_done[g], acc_dd && (spr_x[g] == w - 1));
    if (post_rst[g]) begin
      check("rst_cast_x",      cast_x[g],      0);
      check("rst_cull_x",      cull_x[g],      0);
      check("rst_cull_wall_z", cull_wall_z[g], 0);
      check("rst_draw_x",      draw_x[g],      0);
      post_rst[g] = 0;
    end
    if (cyc == exp_ws[g]) check("cast_x", cast_x[g], cast_col[g]);
    if (spr_busy[g] && cyc >= cs_t[g]) begin
      check("cull_x",      cull_x[g],      spr_x[g]);
      check("cull_wall_z", cull_wall_z[g], spr_z[g]);
      check("draw_x",      draw_x[g],      spr_x[g]);
    end
    if (draw_start[g]) m_draws[g]++;
    if (frame_done[g]) m_fdones[g]++;

    if (rst) begin
      reset_model(g);
      post_rst[g] = 1;
      return;
    end

    if (cyc == exp_ws[g]) begin wait_wd[g] = 1; ws_t[g] = cyc; exp_ws[g] = -1; end
    if (cyc == exp_cs[g]) begin wait_cd[g] = 1; cs_t[g] = cyc; exp_cs[g] = -1; end
    if (cyc == exp_ds[g]) begin wait_dd[g] = 1; ds_t[g] = cyc; exp_ds[g] = -1; end

    if (wall_done[g] && wait_wd[g] && cyc > ws_t[g]) begin
      check("cast_x_hold", cast_x[g], cast_col[g]);
      wait_wd[g] = 0; have_hold[g] = 1;
      hold_x[g] = cast_col[g]; hold_z[g] = wall_z[g]; wd_t[g] = cyc;
    end
    if (cull_done[g] && wait_cd[g] && cyc > cs_t[g]) begin
      wait_cd[g] = 0;
      exp_ds[g]  = cyc + 1;
    end
    if (acc_dd) begin
      wait_dd[g] = 0; spr_busy[g] = 0; free_at[g] = cyc + 1;
      if (spr_x[g] == w - 1) m_in_frame[g] = 0;
    end
    // Transfer happens one cycle after wall_done, or when the sprite path frees up.
    if (have_hold[g] && !spr_busy[g]) begin
      xf = (wd_t[g] + 1 > free_at[g]) ? wd_t[g] + 1 : free_at[g];
      m_stall[g] += xf - wd_t[g] - 1;
      spr_busy[g] = 1; spr_x[g] = hold_x[g]; spr_z[g] = hold_z[g];
      exp_cs[g] = xf + 1; cs_t[g] = xf + 1;
      if (hold_x[g] != w - 1) begin
        cast_col[g]++;
        exp_ws[g] = xf + 1;
      end
      have_hold[g] = 0;
    end

    if (frame_start[g] && !was_in) begin
      m_in_frame[g] = 1; exp_ws[g] = cyc + 1;
      cast_col[g] = 0; free_at[g] = 0;
      m_draws[g] = 0; m_fdones[g] = 0; m_stall[g] = 0; m_busy_cyc[g] = 1;
    end else if (was_in) begin
      m_busy_cyc[g]++;
    end
  endtask

  task automatic respond(input int g);
    nwd[g] = 0; ncd[g] = 0; ndd[g] = 0;
    if (rst) begin
      wc[g] = 0; cc[g] = 0; dc[g] = 0;
    end else begin
      if (wall_start[g]) begin wc[g] = $urandom_range(wl_hi[g], wl_lo[g]); wx[g] = cast_x[g]; end
      if (cull_start[g]) cc[g] = $urandom_range(cl_hi[g], cl_lo[g]);
      if (draw_start[g]) dc[g] = $urandom_range(dl_hi[g], dl_lo[g]);
      if (wc[g] > 0) begin wc[g]--; nwd[g] = (wc[g] == 0); end
      if (cc[g] > 0) begin cc[g]--; ncd[g] = (cc[g] == 0); end
      if (dc[g] > 0) begin dc[g]--; ndd[g] = (dc[g] == 0); end
      if (spur_req[g] != spur_srv[g] && dc[g] >= 2 && !ncd[g]) begin
        ncd[g] = 1;
        spur_srv[g]++;
      end
    end
    nz[g] = nwd[g] ? 16'(16'h0100 + wx[g]) : 16'($urandom);
  endtask

  initial begin : monitor
    for (int g = 0; g < NI; g++) begin
      wall_done[g] = 0; cull_done[g] = 0; draw_done[g] = 0; wall_z[g] = '0;
      wc[g] = 0; cc[g] = 0; dc[g] = 0; spur_srv[g] = 0; post_rst[g] = 0;
      m_draws[g] = 0; m_fdones[g] = 0; m_busy_cyc[g] = 0; m_stall[g] = 0;
      reset_model(g);
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        model_step(g);
        respond(g);
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        wall_done[g] = nwd[g];
        cull_done[g] = ncd[g];
        draw_done[g] = ndd[g];
        wall_z[g]    = nz[g];
      end
    end
  end

  task automatic set_lat(input int g, input int wlo, input int whi, input int clo,
                         input int chi, input int dlo, input int dhi);
    wl_lo[g] = wlo; wl_hi[g] = whi;
    cl_lo[g] = clo; cl_hi[g] = chi;
    dl_lo[g] = dlo; dl_hi[g] = dhi;
  endtask

  // Starts a frame, optionally re-pulses frame_start while busy, waits for the end.
  task automatic run_frame(input int g, input int budget, input int poke);
    bit done = 0;
    @(posedge clk); #1;
    frame_start[g] = 1;
    if (poke > 0) spur_req[g]++;
    @(posedge clk); #1;
    frame_start[g] = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      frame_start[g] = (poke > 0) && (i == poke || i == poke + 9);
      if (!m_in_frame[g]) begin
        done = 1;
        break;
      end
    end
    frame_start[g] = 0;
    check("frame_end_in_budget", done, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    bit found;
    rst = 1;
    for (int g = 0; g < NI; g++) begin
      frame_start[g] = 0;
      spur_req[g]    = 0;
      set_lat(g, 3, 3, 3, 3, 3, 3);
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // Single frame, all units answering in 3 cycles.
    run_frame(0, 2000, 0);
    check("t1_draws",  m_draws[0],  4);
    check("t1_fdones", m_fdones[0], 1);

    // Fast caster, slow line writer: the cast side stalls in transfer.
    set_lat(0, 2, 2, 3, 3, 20, 20);
    run_frame(0, 2000, 0);
    check("t2_draws",  m_draws[0],  4);
    check("t2_fdones", m_fdones[0], 1);
`ifdef COLUMN_SCHED_STATS_EN
    check("t2_stall_nonzero", stall_cycles[0] != 0, 1);
    check("t2_stall_cycles",  stall_cycles[0], m_stall[0]);
    check("t2_frame_cycles",  frame_cycles[0], m_busy_cyc[0]);
`endif

    // frame_start while busy and a stray cull_done during draw are ignored.
    set_lat(0, 1, 4, 1, 4, 3, 6);
    run_frame(0, 2000, 6);
    check("t4_draws",     m_draws[0],  4);
    check("t4_fdones",    m_fdones[0], 1);
    check("t4_spur_sent", spur_srv[0], spur_req[0]);

    // Reset during column 2, then a clean restart from column 0.
    set_lat(0, 3, 3, 3, 3, 3, 3);
    @(posedge clk); #1 frame_start[0] = 1;
    @(posedge clk); #1 frame_start[0] = 0;
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wall_start[0] && cast_x[0] == 9'd2) begin
        found = 1;
        break;
      end
    end
    check("t5_reached_col2", found, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_fdone_after_rst", m_fdones[0], 0);
    run_frame(0, 2000, 0);
    check("t5_draws",  m_draws[0],  4);
    check("t5_fdones", m_fdones[0], 1);

    // Full 320-column frame with random 1..10 cycle unit latencies.
    set_lat(1, 1, 10, 1, 10, 1, 10);
    run_frame(1, 30000, 0);
    check("t6_draws",  m_draws[1],  320);
    check("t6_fdones", m_fdones[1], 1);
`ifdef COLUMN_SCHED_STATS_EN
    check("t6_frame_cycles", frame_cycles[1], m_busy_cyc[1]);
    check("t6_stall_cycles", stall_cycles[1], m_stall[1]);
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
